// File: rtl/break_bits_sequencer_pkg.sv
// Shared SAT parameters and sequencer state encoding, used by the sequencer and the selector side.
package break_bits_sequencer_pkg;

  localparam int unsigned SAT_MC        = 20;
  localparam int unsigned SAT_NSAT      = 3;
  localparam int unsigned SAT_NSAT_BITS = 2;
  localparam int unsigned SAT_VAR_BITS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT,
    DECIDE,
    RESULT
  } seq_state_e;

endpackage

// File: rtl/break_bits_compute.sv
// Break-bit and slot-mask generation from occurrence-memory read data.
// With CAND_VALID_MASK_EN defined, invalid candidates emit all-zero bits.
module break_bits_compute
  import break_bits_sequencer_pkg::*;
#(
  parameter int unsigned MC = SAT_MC
) (
  input  logic          active,
  input  logic          cand_ok,
  input  logic [MC-1:0] one_true,
  input  logic [MC-1:0] lit_true,
  input  logic [MC-1:0] occ_valid,
  output logic [MC-1:0] clause_broken,
  output logic [MC-1:0] mask_bits
);

  logic en;

`ifdef CAND_VALID_MASK_EN
  assign en = active & cand_ok;
`else
  logic unused_cand_ok;
  assign unused_cand_ok = cand_ok;
  assign en = active;
`endif

  assign clause_broken = en ? (one_true & lit_true & occ_valid) : '0;
  assign mask_bits     = en ? occ_valid : '0;

endmodule

// File: rtl/break_bits_sequencer.sv
// Fetches occurrence data for NSAT flip candidates, streams break bits to the selector
// and returns the chosen variable. Optional feature macro: CAND_VALID_MASK_EN.
module break_bits_sequencer
  import break_bits_sequencer_pkg::*;
#(
  parameter int unsigned MAX_CLAUSES_PER_VARIABLE = SAT_MC,
  parameter int unsigned NSAT                     = SAT_NSAT,
  parameter int unsigned NSAT_BITS                = SAT_NSAT_BITS,
  parameter int unsigned VAR_BITS                 = SAT_VAR_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_i,
  input  logic [NSAT*VAR_BITS-1:0]            cand_vars_i,
  input  logic [NSAT-1:0]                     cand_valid_i,
  output logic                                busy_o,
  output logic                                rd_en_o,
  output logic [VAR_BITS-1:0]                 rd_addr_o,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] rd_one_true_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] rd_lit_true_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] rd_occ_valid_i,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
  output logic [NSAT_BITS-1:0]                wren_o,
  output logic [NSAT-1:0]                     break_values_valid_o,
  input  logic [NSAT_BITS-1:0]                selected_i,
  output logic [VAR_BITS-1:0]                 flip_var_o,
  output logic                                flip_valid_o,
  output logic                                flip_none_o
);

  localparam int unsigned MC = MAX_CLAUSES_PER_VARIABLE;

  typedef logic [NSAT-1:0][VAR_BITS-1:0] cand_t;

  seq_state_e           state_q, state_d;
  logic [NSAT_BITS-1:0] idx_q, idx_d, nxt_idx;
  cand_t                cand_in, cand_q, cand_src;
  logic [NSAT-1:0]      valid_src;
  logic                 cap;
  logic                 emit_q, emit_d, emit_ok_q, emit_ok_d;
  logic                 busy_d, rd_en_d, flip_valid_d, flip_none_d;
  logic [VAR_BITS-1:0]  rd_addr_d, flip_var_d;
  logic [NSAT_BITS-1:0] wren_d;
  logic [NSAT-1:0]      bvv_d;

  assign cand_in = cand_vars_i;

`ifdef CAND_VALID_MASK_EN
  logic [NSAT-1:0] valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    valid_q <= '0;
    else if (cap) valid_q <= cand_valid_i;
  end

  assign valid_src = cap ? cand_valid_i : valid_q;
`else
  logic unused_cand_valid;
  assign unused_cand_valid = ^cand_valid_i;
  assign valid_src = '1;
`endif

  // Next state; emission index counts EMIT cycles
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          cap     = 1'b1;
        end
      end
      FETCH: begin
        state_d = EMIT;
        idx_d   = '0;
      end
      EMIT: begin
        if (idx_q == NSAT_BITS'(NSAT - 1)) state_d = DECIDE;
        else                               idx_d   = idx_q + 1'b1;
      end
      DECIDE:  state_d = RESULT;
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops cleanly
  always_comb begin
    cand_src     = cap ? cand_in : cand_q;
    nxt_idx      = idx_d + 1'b1;
    busy_d       = (state_d != IDLE);
    rd_en_d      = 1'b0;
    rd_addr_d    = '0;
    wren_d       = '0;
    bvv_d        = '0;
    emit_d       = 1'b0;
    emit_ok_d    = 1'b0;
    flip_valid_d = 1'b0;
    flip_var_d   = '0;
    flip_none_d  = 1'b0;
    if (state_d == FETCH) begin
      rd_en_d   = 1'b1;
      rd_addr_d = cand_src[0];
    end
    if (state_d == EMIT) begin
      emit_d    = 1'b1;
      emit_ok_d = valid_src[idx_d];
      wren_d    = nxt_idx;
      if (idx_d == NSAT_BITS'(NSAT - 1)) begin
        bvv_d = valid_src;
      end else begin
        rd_en_d   = 1'b1;
        rd_addr_d = cand_src[nxt_idx];
      end
    end
    if (state_q == DECIDE) begin
      flip_valid_d = 1'b1;
      if (32'(selected_i) < NSAT) flip_var_d  = cand_q[selected_i];
      else                        flip_none_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      idx_q                <= '0;
      cand_q               <= '0;
      emit_q               <= 1'b0;
      emit_ok_q            <= 1'b0;
      busy_o               <= 1'b0;
      rd_en_o              <= 1'b0;
      rd_addr_o            <= '0;
      wren_o               <= '0;
      break_values_valid_o <= '0;
      flip_valid_o         <= 1'b0;
      flip_var_o           <= '0;
      flip_none_o          <= 1'b0;
    end else begin
      state_q              <= state_d;
      idx_q                <= idx_d;
      if (cap) cand_q      <= cand_in;
      emit_q               <= emit_d;
      emit_ok_q            <= emit_ok_d;
      busy_o               <= busy_d;
      rd_en_o              <= rd_en_d;
      rd_addr_o            <= rd_addr_d;
      wren_o               <= wren_d;
      break_values_valid_o <= bvv_d;
      flip_valid_o         <= flip_valid_d;
      flip_var_o           <= flip_var_d;
      flip_none_o          <= flip_none_d;
    end
  end

  break_bits_compute #(
    .MC(MC)
  ) u_compute (
    .active        (emit_q),
    .cand_ok       (emit_ok_q),
    .one_true      (rd_one_true_i),
    .lit_true      (rd_lit_true_i),
    .occ_valid     (rd_occ_valid_i),
    .clause_broken (clause_broken_o),
    .mask_bits     (mask_bits_o)
  );

endmodule

// File: tb/tb_break_bits_sequencer.sv
// Self-checking bench for break_bits_sequencer: vector table, random sequences, reset abort.
module tb_break_bits_sequencer;

  localparam int unsigned MC = 20;
  localparam int unsigned NS = 3;
  localparam int unsigned NB = 2;
  localparam int unsigned VB = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_i = 1'b0;
  logic [NS-1:0][VB-1:0] cand_vars_i = '0;
  logic [NS-1:0]     cand_valid_i = '0;
  logic              busy_o, rd_en_o, flip_valid_o, flip_none_o;
  logic [VB-1:0]     rd_addr_o, flip_var_o;
  logic [MC-1:0]     one_t = '0, lit_t = '0, occ_t = '0;
  logic [MC-1:0]     clause_broken_o, mask_bits_o;
  logic [NB-1:0]     wren_o;
  logic [NS-1:0]     break_values_valid_o;
  logic [NB-1:0]     selected_i = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [MC-1:0] last_cb0, last_mask0;

  break_bits_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .cand_vars_i(cand_vars_i),
    .cand_valid_i(cand_valid_i), .busy_o(busy_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_one_true_i(one_t), .rd_lit_true_i(lit_t), .rd_occ_valid_i(occ_t),
    .clause_broken_o(clause_broken_o), .mask_bits_o(mask_bits_o), .wren_o(wren_o),
    .break_values_valid_o(break_values_valid_o), .selected_i(selected_i),
    .flip_var_o(flip_var_o), .flip_valid_o(flip_valid_o), .flip_none_o(flip_none_o)
  );

  always #5 clk = ~clk;

  // Occurrence memory contents: deterministic hash per variable, one special entry
  function automatic logic [MC-1:0] mem_word(input logic [VB-1:0] a, input int fld);
    logic [31:0] x;
    if (a == 16'd777) begin
      case (fld)
        0:       return 20'hFFFFF;
        1:       return 20'h00200;
        default: return 20'h003FF;
      endcase
    end
    x = 32'(a) * 32'h9E3779B1 + 32'(fld) * 32'h7F4A7C15;
    x = x ^ (x >> 13);
    x = x * 32'h85EBCA6B;
    return x[MC-1:0] ^ x[31:12];
  endfunction

  // Registered read port, one-cycle latency
  always @(posedge clk) begin
    if (rd_en_o) begin
      one_t <= mem_word(rd_addr_o, 0);
      lit_t <= mem_word(rd_addr_o, 1);
      occ_t <= mem_word(rd_addr_o, 2);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 64'(busy_o), 0);
    chk({tag, " rd_en"}, 64'(rd_en_o), 0);
    chk({tag, " rd_addr"}, 64'(rd_addr_o), 0);
    chk({tag, " wren"}, 64'(wren_o), 0);
    chk({tag, " cb"}, 64'(clause_broken_o), 0);
    chk({tag, " mask"}, 64'(mask_bits_o), 0);
    chk({tag, " bvv"}, 64'(break_values_valid_o), 0);
    chk({tag, " flip_valid"}, 64'(flip_valid_o), 0);
    chk({tag, " flip_var"}, 64'(flip_var_o), 0);
    chk({tag, " flip_none"}, 64'(flip_none_o), 0);
  endtask

  // One full candidate evaluation checked cycle by cycle; t counts cycles after start_i
  task automatic run_seq(input logic [NS-1:0][VB-1:0] c, input logic [NS-1:0] v,
                         input logic [NB-1:0] sel, input logic [VB-1:0] ev,
                         input logic en, input bit hold);
    logic [NS-1:0] vm;
    logic [MC-1:0] e_cb, e_mask;
    int k;
`ifdef CAND_VALID_MASK_EN
    vm = v;
`else
    vm = '1;
`endif
    @(negedge clk);
    start_i = 1'b1; cand_vars_i = c; cand_valid_i = v; selected_i = ~sel;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      k = t - 2;
      e_cb = '0; e_mask = '0;
      if (t >= 2 && t <= 4 && vm[k]) begin
        e_cb   = mem_word(c[k], 0) & mem_word(c[k], 1) & mem_word(c[k], 2);
        e_mask = mem_word(c[k], 2);
      end
      chk($sformatf("t%0d busy", t), 64'(busy_o), 64'(t <= 6));
      chk($sformatf("t%0d rd_en", t), 64'(rd_en_o), 64'(t <= 3));
      chk($sformatf("t%0d rd_addr", t), 64'(rd_addr_o), (t <= 3) ? 64'(c[t-1]) : 0);
      chk($sformatf("t%0d wren", t), 64'(wren_o), (t >= 2 && t <= 4) ? 64'(t - 1) : 0);
      chk($sformatf("t%0d cb", t), 64'(clause_broken_o), 64'(e_cb));
      chk($sformatf("t%0d mask", t), 64'(mask_bits_o), 64'(e_mask));
      chk($sformatf("t%0d bvv", t), 64'(break_values_valid_o), (t == 4) ? 64'(vm) : 0);
      chk($sformatf("t%0d flip_valid", t), 64'(flip_valid_o), 64'(t == 6));
      chk($sformatf("t%0d flip_var", t), 64'(flip_var_o), (t == 6) ? 64'(ev) : 0);
      chk($sformatf("t%0d flip_none", t), 64'(flip_none_o), (t == 6) ? 64'(en) : 0);
      if (t == 2) begin last_cb0 = clause_broken_o; last_mask0 = mask_bits_o; end
      if (!hold) start_i = 1'b0;
      cand_vars_i = ~c; cand_valid_i = ~v;
      if (t == 5) selected_i = sel;
      if (t == 6) selected_i = ~sel;
    end
  endtask

  typedef struct {
    logic [NS-1:0][VB-1:0] cands;
    logic [NS-1:0]         valid;
    logic [NB-1:0]         sel;
    logic [VB-1:0]         exp_var;
    logic                  exp_none;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [NS-1:0][VB-1:0] rc;
    logic [NS-1:0] rv;
    logic [NB-1:0] rs;
    int pulses;
    bit done;

    tbl[0] = '{cands: {16'd12, 16'd9, 16'd5}, valid: 3'b111, sel: 2'd1, exp_var: 16'd9, exp_none: 1'b0};
    tbl[1] = '{cands: {16'd12, 16'd9, 16'd5}, valid: 3'b111, sel: 2'd0, exp_var: 16'd5, exp_none: 1'b0};
    tbl[2] = '{cands: {16'd12, 16'd9, 16'd5}, valid: 3'b101, sel: 2'd2, exp_var: 16'd12, exp_none: 1'b0};
    tbl[3] = '{cands: {16'd12, 16'd9, 16'd5}, valid: 3'b111, sel: 2'd3, exp_var: 16'd0, exp_none: 1'b1};
    tbl[4] = '{cands: {16'd2, 16'd1, 16'd777}, valid: 3'b111, sel: 2'd0, exp_var: 16'd777, exp_none: 1'b0};
    tbl[5] = '{cands: {16'd3, 16'hFFFF, 16'd1}, valid: 3'b011, sel: 2'd1, exp_var: 16'hFFFF, exp_none: 1'b0};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    for (int i = 0; i < 6; i++)
      run_seq(tbl[i].cands, tbl[i].valid, tbl[i].sel, tbl[i].exp_var, tbl[i].exp_none, 1'b0);

    // Special memory entry presented as candidate 0
    run_seq({16'd2, 16'd1, 16'd777}, 3'b111, 2'd2, 16'd2, 1'b0, 1'b0);
    chk("special cb", 64'(last_cb0), 64'h00200);
    chk("special mask", 64'(last_mask0), 64'h003FF);

    // Random sequences against the candidate-selection model
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < NS; j++) rc[j] = VB'($urandom);
      rv = NS'($urandom);
      rs = NB'($urandom_range(0, 3));
      run_seq(rc, rv, rs, (rs < NS) ? rc[rs] : '0, rs >= NS, 1'b0);
    end

    // start_i held high: one sequence, then a fresh one from the next IDLE cycle
    run_seq({16'd12, 16'd9, 16'd5}, 3'b111, 2'd1, 16'd9, 1'b0, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    chk("restart busy", 64'(busy_o), 1);
    pulses = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (flip_valid_o) pulses++;
      if (!busy_o) done = 1;
    end
    chk("restart done", 64'(done), 1);
    chk("restart pulses", 64'(pulses), 1);

    // Reset during EMIT aborts immediately
    @(negedge clk);
    start_i = 1'b1; cand_vars_i = {16'd12, 16'd9, 16'd5}; cand_valid_i = '1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("pre-abort wren", 64'(wren_o), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("post-abort%0d fv", i), 64'(flip_valid_o), 0);
      chk($sformatf("post-abort%0d busy", i), 64'(busy_o), 0);
    end
    run_seq({16'd40, 16'd30, 16'd20}, 3'b110, 2'd2, 16'd40, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/break_bits_sequencer.md
BREAK_BITS_SEQUENCER -- requirements
Module: break_bits_sequencer

Interface
REQ-001 SHALL have parameters: MAX_CLAUSES_PER_VARIABLE, default 20, clause slots per variable (MC); NSAT, default 3, candidates per flip; NSAT_BITS, default 2, candidate index width; VAR_BITS, default 16, variable-ID width.
REQ-002 SHALL have ports, one clock, asynchronous active-high reset:
 clk  in  1  clock
 reset  in  1  asynchronous, active-high
 start_i  in  1  begin one candidate evaluation
 cand_vars_i  in  NSAT*VAR_BITS  candidate IDs, candidate 0 in LSBs
 cand_valid_i  in  NSAT  per-candidate valid
 busy_o  out  1  sequence in progress
 rd_en_o  out  1  occurrence-memory read strobe
 rd_addr_o  out  VAR_BITS  variable ID to read
 rd_one_true_i  in  MC  clause has exactly one true literal
 rd_lit_true_i  in  MC  this variable's literal is true in clause
 rd_occ_valid_i  in  MC  slot occupied
 clause_broken_o  out  MC  break bits to selector
 mask_bits_o  out  MC  slot mask to selector
 wren_o  out  NSAT_BITS  selector write slot, 0 = idle
 break_values_valid_o  out  NSAT  candidate valid to selector
 selected_i  in  NSAT_BITS  selector result
 flip_var_o  out  VAR_BITS  chosen variable
 flip_valid_o  out  1  one-cycle result strobe
 flip_none_o  out  1  selector returned out-of-range index

Function
REQ-003 SHALL use FSM states IDLE, FETCH, EMIT, DECIDE, RESULT.
REQ-004 In IDLE, start_i=1 SHALL capture cand_vars_i/cand_valid_i and enter FETCH; busy_o SHALL be 1 in every non-IDLE state.
REQ-005 FETCH (1 cycle) SHALL drive rd_en_o=1, rd_addr_o=candidate 0.
REQ-006 EMIT SHALL last NSAT cycles, index k=0..NSAT-1; cycle k SHALL drive wren_o=k+1 and present candidate k's read data; for k<NSAT-1 it SHALL also drive rd_en_o=1, rd_addr_o=candidate k+1.
REQ-007 Memory read latency SHALL be exactly 1 cycle; data SHALL be used combinationally in the EMIT cycle following the address.
REQ-008 clause_broken_o SHALL equal rd_one_true_i & rd_lit_true_i & rd_occ_valid_i; mask_bits_o SHALL equal rd_occ_valid_i; both SHALL be 0 outside EMIT.
REQ-009 break_values_valid_o SHALL be asserted only in EMIT cycle k=NSAT-1, else 0.
REQ-010 DECIDE (1 cycle, wren_o=0) SHALL sample selected_i; RESULT (1 cycle) SHALL pulse flip_valid_o with flip_var_o = candidate[selected_i], then return to IDLE.
REQ-011 selected_i >= NSAT SHALL give flip_none_o=1, flip_var_o=0 with the flip_valid_o pulse.
REQ-012 Start-to-flip_valid_o latency SHALL be NSAT+3 cycles; start_i while busy SHALL be ignored; start_i in RESULT SHALL NOT start a new sequence (accepted next IDLE cycle).
REQ-013 rd_addr_o SHALL be 0 when rd_en_o=0.

Reset
REQ-014 reset SHALL force IDLE and all outputs 0 asynchronously; reset mid-sequence SHALL abort without flip_valid_o and drop captured candidates.

Configuration
REQ-015 With CAND_VALID_MASK_EN defined: break_values_valid_o = captured cand_valid_i, and clause_broken_o/mask_bits_o forced 0 for invalid candidates (read still issued); without it: break_values_valid_o all ones, cand_valid_i ignored.

Structure
REQ-016 State encoding, MC/NSAT/VAR_BITS defaults SHALL live in a shared SAT package used also by the selector side.
REQ-017 One sub-module, break_bits_compute, SHALL hold the REQ-008/REQ-015 combinational masking; FSM and capture registers stay in the top.

Verification
REQ-018 Cands 5,9,12, memory model 1-cycle latency -> rd_addr_o 5,9,12 on consecutive cycles, wren_o 1,2,3 next cycles, break_values_valid_o=3'b111 only with wren_o=3.
REQ-019 one_true=20'hFFFFF, lit_true=20'h00200, occ=20'h003FF -> clause_broken_o=20'h00200, mask_bits_o=20'h003FF.
REQ-020 selected_i=1 in DECIDE, cands 5,9,12 -> flip_valid_o pulse with flip_var_o=9 exactly NSAT+3 cycles after start_i.
REQ-021 selected_i=3 -> flip_none_o=1, flip_var_o=0; reset asserted during EMIT -> outputs 0 immediately, no flip_valid_o.
REQ-022 CAND_VALID_MASK_EN defined, cand_valid_i=3'b101 -> break_values_valid_o=3'b101, candidate 1 emits clause_broken_o=0, mask_bits_o=0; start_i held through sequence -> exactly one sequence per IDLE entry.
